ysyx_22040386_idu_stage: RTL and testbench

//  Registered, parametrised decode stage between IFU and EXU. Decodes RV32I/RV64I base opcodes
//  (LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, OP-IMM-32, OP-32) into imm and control.
//  One pipeline register with valid/ready handshakes, flush, sticky ebreak halt, illegal-opcode flag.

---
 rtl/ysyx_22040386_pkg.sv | 69 ++++++
 rtl/ysyx_22040386_imm_gen.sv | 35 +++
 rtl/ysyx_22040386_idu_stage.sv | 199 +++++++++++++++++++
 tb/tb_ysyx_22040386_idu_stage.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040386_pkg.sv
// Shared decode definitions for the ysyx_22040386 IDU: opcodes, ALU operation
// encoding, the registered control bundle and funct3-to-ALU mapping.
package ysyx_22040386_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_COPYB = 4'd10,
    ALU_PC4   = 4'd11
  } alu_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    alu_e       alu_ctr;
    logic       asrc;
    logic       bsrc;
    logic       word;
    logic       reg_wr;
    logic       jump;
    logic       branch;
    logic       mem_rd;
    logic       mem_wr;
    logic [2:0] funct3;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB for funct3=000 and SRA for funct3=101
  function automatic alu_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_e r;
    case (f3)
      3'b000:  r = alt ? ALU_SUB : ALU_ADD;
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b011:  r = ALU_SLTU;
      3'b100:  r = ALU_XOR;
      3'b101:  r = alt ? ALU_SRA : ALU_SRL;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22040386_imm_gen.sv
// Combinational immediate generator: selects the I/S/B/J/U format from the
// opcode and sign-extends from inst[31] to XLEN.
module ysyx_22040386_imm_gen
  import ysyx_22040386_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     i_inst,
  output logic [XLEN-1:0] o_imm
);

  logic [31:0] w_imm32;

  // Format select on the 32-bit view; widening happens once below
  always_comb begin
    w_imm32 = 32'd0;
    case (i_inst[6:0])
      OPC_LUI, OPC_AUIPC:
        w_imm32 = {i_inst[31:12], 12'd0};
      OPC_JAL:
        w_imm32 = {{12{i_inst[31]}}, i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32:
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      OPC_STORE:
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      OPC_BRANCH:
        w_imm32 = {{20{i_inst[31]}}, i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      default:
        w_imm32 = 32'd0;
    endcase
  end

  assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/ysyx_22040386_idu_stage.sv
// RV32I/RV64I decode stage: combinational decode into one valid/ready output
// register bank, with flush, illegal-encoding flag and a sticky ebreak halt.
module ysyx_22040386_idu_stage
  import ysyx_22040386_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit EN_RV64W = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [3:0]      out_alu_ctr,
  output logic            out_asrc,
  output logic            out_bsrc,
  output logic            out_word,
  output logic            out_reg_wr,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_mem_rd,
  output logic            out_mem_wr,
  output logic [2:0]      out_funct3,
  output logic            out_illegal,
  output logic            halt
);

  localparam bit RV64 = (XLEN == 64);
  localparam bit W_EN = RV64 && EN_RV64W;

  logic [XLEN-1:0] w_imm_raw, w_imm, r_pc, r_imm;
  ctrl_t           w_ctrl, r_ctrl;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic            w_ill, w_sh5_ok, w_sh6_ok, w_accept;
  logic            r_valid, r_halt;

  ysyx_22040386_imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .i_inst (in_inst),
    .o_imm  (w_imm_raw)
  );

  assign w_f3 = in_inst[14:12];
  assign w_f7 = in_inst[31:25];
  // Shift-immediate upper bits may only carry the SRA selector (inst[30]) on a right shift
  assign w_sh5_ok = ~(in_inst[31] | (|in_inst[29:25])) & ((w_f3 == 3'b101) | ~in_inst[30]);
  assign w_sh6_ok = ~(in_inst[31] | (|in_inst[29:26])) & ((w_f3 == 3'b101) | ~in_inst[30]);

  // Decode opcode/funct fields into the control bundle and final immediate
  always_comb begin
    w_ctrl        = '0;
    w_ctrl.rs1    = in_inst[19:15];
    w_ctrl.rs2    = in_inst[24:20];
    w_ctrl.rd     = in_inst[11:7];
    w_ctrl.funct3 = w_f3;
    w_imm         = w_imm_raw;
    w_ill         = 1'b0;
    case (in_inst[6:0])
      OPC_LUI: begin
        w_ctrl.alu_ctr = ALU_COPYB; w_ctrl.bsrc = 1'b1; w_ctrl.reg_wr = 1'b1;
      end
      OPC_AUIPC: begin
        w_ctrl.alu_ctr = ALU_ADD; w_ctrl.asrc = 1'b1; w_ctrl.bsrc = 1'b1; w_ctrl.reg_wr = 1'b1;
      end
      OPC_JAL: begin
        w_ctrl.alu_ctr = ALU_PC4; w_ctrl.asrc = 1'b1; w_ctrl.bsrc = 1'b1;
        w_ctrl.jump = 1'b1; w_ctrl.reg_wr = 1'b1;
      end
      OPC_JALR: begin
        w_ctrl.alu_ctr = ALU_PC4; w_ctrl.bsrc = 1'b1; w_ctrl.jump = 1'b1; w_ctrl.reg_wr = 1'b1;
        w_ill = (w_f3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_ctrl.alu_ctr = ALU_SUB; w_ctrl.branch = 1'b1;
        w_ill = (w_f3[2:1] == 2'b01);
      end
      OPC_LOAD: begin
        w_ctrl.alu_ctr = ALU_ADD; w_ctrl.bsrc = 1'b1; w_ctrl.mem_rd = 1'b1; w_ctrl.reg_wr = 1'b1;
        w_ill = (w_f3 == 3'b111) | (~RV64 & ((w_f3 == 3'b011) | (w_f3 == 3'b110)));
      end
      OPC_STORE: begin
        w_ctrl.alu_ctr = ALU_ADD; w_ctrl.bsrc = 1'b1; w_ctrl.mem_wr = 1'b1;
        w_ill = w_f3[2] | (~RV64 & (w_f3 == 3'b011));
      end
      OPC_OP_IMM: begin
        w_ctrl.alu_ctr = alu_from_f3(w_f3, (w_f3 == 3'b101) & in_inst[30]);
        w_ctrl.bsrc    = 1'b1;
        w_ctrl.reg_wr  = 1'b1;
        if (w_f3[1:0] == 2'b01) begin
          w_ill = RV64 ? ~w_sh6_ok : ~w_sh5_ok;
          w_imm = RV64 ? XLEN'(in_inst[25:20]) : XLEN'(in_inst[24:20]);
        end else begin
          w_ill = 1'b0;
        end
      end
      OPC_OP: begin
        w_ctrl.alu_ctr = alu_from_f3(w_f3, w_f7[5]);
        w_ctrl.reg_wr  = 1'b1;
        w_imm          = '0;
        w_ill = ~((w_f7 == 7'b0000000) |
                  ((w_f7 == 7'b0100000) & ((w_f3 == 3'b000) | (w_f3 == 3'b101))));
      end
      OPC_OP_IMM_32: begin
        w_ctrl.alu_ctr = alu_from_f3(w_f3, (w_f3 == 3'b101) & in_inst[30]);
        w_ctrl.bsrc    = 1'b1;
        w_ctrl.word    = 1'b1;
        w_ctrl.reg_wr  = 1'b1;
        if (w_f3[1:0] == 2'b01) begin
          w_imm = XLEN'(in_inst[24:20]);
        end else begin
          w_imm = w_imm_raw;
        end
        w_ill = ~W_EN | ~((w_f3 == 3'b000) | ((w_f3[1:0] == 2'b01) & ~w_f3[1] & w_sh5_ok));
      end
      OPC_OP_32: begin
        w_ctrl.alu_ctr = alu_from_f3(w_f3, w_f7[5]);
        w_ctrl.word    = 1'b1;
        w_ctrl.reg_wr  = 1'b1;
        w_imm          = '0;
        w_ill = ~W_EN |
                ~((w_f3 == 3'b000) | (w_f3 == 3'b001) | (w_f3 == 3'b101)) |
                ~((w_f7 == 7'b0000000) | ((w_f7 == 7'b0100000) & (w_f3 != 3'b001)));
      end
      OPC_SYSTEM: begin
        w_ill = (in_inst != EBREAK);
      end
      default: begin
        w_ill = 1'b1;
      end
    endcase
    // Illegal encodings still flow downstream but must not cause side effects
    if (w_ill) begin
      w_ctrl.illegal = 1'b1; w_ctrl.reg_wr = 1'b0; w_ctrl.mem_rd = 1'b0;
      w_ctrl.mem_wr  = 1'b0; w_ctrl.jump   = 1'b0; w_ctrl.branch = 1'b0;
      w_ctrl.word    = 1'b0;
    end else begin
      w_ctrl.illegal = 1'b0;
    end
  end

  assign in_ready = ~r_halt & (~r_valid | out_ready);
  assign w_accept = in_valid & in_ready & ~flush;

  // Pipeline register, valid bit and sticky halt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
      r_pc    <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pc   <= in_pc;
        r_imm  <= w_imm;
        r_ctrl <= w_ctrl;
        if (in_inst == EBREAK) begin
          r_halt <= 1'b1;
        end
      end
    end
  end

  assign out_valid   = r_valid;
  assign halt        = r_halt;
  assign out_pc      = r_pc;
  assign out_imm     = r_imm;
  assign out_rs1     = r_ctrl.rs1;
  assign out_rs2     = r_ctrl.rs2;
  assign out_rd      = r_ctrl.rd;
  assign out_alu_ctr = r_ctrl.alu_ctr;
  assign out_asrc    = r_ctrl.asrc;
  assign out_bsrc    = r_ctrl.bsrc;
  assign out_word    = r_ctrl.word;
  assign out_reg_wr  = r_ctrl.reg_wr;
  assign out_jump    = r_ctrl.jump;
  assign out_branch  = r_ctrl.branch;
  assign out_mem_rd  = r_ctrl.mem_rd;
  assign out_mem_wr  = r_ctrl.mem_wr;
  assign out_funct3  = r_ctrl.funct3;
  assign out_illegal = r_ctrl.illegal;

endmodule

// File: tb/tb_ysyx_22040386_idu_stage.sv
// Directed bench for the IDU stage: one RV64 (W ops on) instance and one RV32
// instance driven by the same handshake stimulus.
module tb_ysyx_22040386_idu_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, flush, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic [31:0] in_pc32;

  logic        in_ready, out_valid, halt;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [3:0]  out_alu_ctr;
  logic        out_asrc, out_bsrc, out_word, out_reg_wr, out_jump, out_branch;
  logic        out_mem_rd, out_mem_wr, out_illegal;
  logic [2:0]  out_funct3;

  logic        b_in_ready, b_out_valid, b_halt;
  logic [31:0] b_out_pc, b_out_imm;
  logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
  logic [3:0]  b_out_alu_ctr;
  logic        b_out_asrc, b_out_bsrc, b_out_word, b_out_reg_wr, b_out_jump, b_out_branch;
  logic        b_out_mem_rd, b_out_mem_wr, b_out_illegal;
  logic [2:0]  b_out_funct3;

  int n_checks = 0;
  int n_errors = 0;

  assign in_pc32 = in_pc[31:0];

  always #5 clk = ~clk;

  ysyx_22040386_idu_stage #(.XLEN(64), .EN_RV64W(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_alu_ctr(out_alu_ctr), .out_asrc(out_asrc),
    .out_bsrc(out_bsrc), .out_word(out_word), .out_reg_wr(out_reg_wr), .out_jump(out_jump),
    .out_branch(out_branch), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
    .out_funct3(out_funct3), .out_illegal(out_illegal), .halt(halt)
  );

  ysyx_22040386_idu_stage #(.XLEN(32), .EN_RV64W(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_inst(in_inst), .in_pc(in_pc32), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_out_pc), .out_imm(b_out_imm), .out_rs1(b_out_rs1),
    .out_rs2(b_out_rs2), .out_rd(b_out_rd), .out_alu_ctr(b_out_alu_ctr), .out_asrc(b_out_asrc),
    .out_bsrc(b_out_bsrc), .out_word(b_out_word), .out_reg_wr(b_out_reg_wr),
    .out_jump(b_out_jump), .out_branch(b_out_branch), .out_mem_rd(b_out_mem_rd),
    .out_mem_wr(b_out_mem_wr), .out_funct3(b_out_funct3), .out_illegal(b_out_illegal),
    .halt(b_halt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] inst, input logic [63:0] pc);
    in_valid = v;
    in_inst  = inst;
    in_pc    = pc;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0000_0000, 64'h0);
    step(); step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_halt", {63'd0, halt}, 64'd0);
    chk("rst_imm", out_imm, 64'd0);
    chk("rst_alu", {60'd0, out_alu_ctr}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // lui x5, 0x12345
    rst_n = 1'b1;
    drive(1'b1, 32'h1234_52B7, 64'h0000_0000_8000_0000);
    step();
    chk("lui_valid", {63'd0, out_valid}, 64'd1);
    chk("lui_imm", out_imm, 64'h0000_0000_1234_5000);
    chk("lui_alu", {60'd0, out_alu_ctr}, 64'd10);
    chk("lui_rd", {59'd0, out_rd}, 64'd5);
    chk("lui_reg_wr", {63'd0, out_reg_wr}, 64'd1);
    chk("lui_pc", out_pc, 64'h0000_0000_8000_0000);

    // addi x1, x0, -1 accepted while the lui is consumed
    drive(1'b1, 32'hFFF0_0093, 64'h0000_0000_8000_0004);
    step();
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_imm64", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_imm32", {32'd0, b_out_imm}, 64'h0000_0000_FFFF_FFFF);
    chk("addi_alu", {60'd0, out_alu_ctr}, 64'd0);
    chk("addi_rd", {59'd0, out_rd}, 64'd1);
    chk("addi_bsrc", {63'd0, out_bsrc}, 64'd1);

    // add x3, x1, x2 under three cycles of backpressure
    out_ready = 1'b0;
    drive(1'b1, 32'h0020_81B3, 64'h0000_0000_8000_0008);
    #1;
    chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_rd_held", {59'd0, out_rd}, 64'd1);
      chk("bp_imm_held", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
    step();
    chk("add_rd", {59'd0, out_rd}, 64'd3);
    chk("add_imm", out_imm, 64'd0);
    chk("add_bsrc", {63'd0, out_bsrc}, 64'd0);
    chk("add_pc", out_pc, 64'h0000_0000_8000_0008);

    // sub x4, x1, x2
    drive(1'b1, 32'h4020_8233, 64'h0000_0000_8000_000C);
    step();
    chk("sub_alu", {60'd0, out_alu_ctr}, 64'd1);
    chk("sub_illegal", {63'd0, out_illegal}, 64'd0);

    // flush kills an incoming lui x7
    flush = 1'b1;
    drive(1'b1, 32'h0000_03B7, 64'h0000_0000_8000_0010);
    step();
    chk("flush_valid", {63'd0, out_valid}, 64'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0000_0000, 64'h0);
    step();
    chk("flush_not_emitted", {63'd0, out_valid}, 64'd0);

    // addiw x1, x1, 1
    drive(1'b1, 32'h0010_809B, 64'h0000_0000_8000_0014);
    step();
    chk("addiw_word", {63'd0, out_word}, 64'd1);
    chk("addiw_alu", {60'd0, out_alu_ctr}, 64'd0);
    chk("addiw_illegal", {63'd0, out_illegal}, 64'd0);
    chk("addiw_imm", out_imm, 64'd1);
    chk("addiw32_illegal", {63'd0, b_out_illegal}, 64'd1);
    chk("addiw32_reg_wr", {63'd0, b_out_reg_wr}, 64'd0);
    chk("addiw32_valid", {63'd0, b_out_valid}, 64'd1);

    // beq x1, x2, -4
    drive(1'b1, 32'hFE20_8EE3, 64'h0000_0000_8000_0018);
    step();
    chk("beq_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("beq_branch", {63'd0, out_branch}, 64'd1);
    chk("beq_alu", {60'd0, out_alu_ctr}, 64'd1);
    chk("beq_reg_wr", {63'd0, out_reg_wr}, 64'd0);

    // sd x2, 8(x1): legal on RV64 only
    drive(1'b1, 32'h0020_B423, 64'h0000_0000_8000_001C);
    step();
    chk("sd_imm", out_imm, 64'd8);
    chk("sd_mem_wr", {63'd0, out_mem_wr}, 64'd1);
    chk("sd_reg_wr", {63'd0, out_reg_wr}, 64'd0);
    chk("sd_funct3", {61'd0, out_funct3}, 64'd3);
    chk("sd32_illegal", {63'd0, b_out_illegal}, 64'd1);
    chk("sd32_mem_wr", {63'd0, b_out_mem_wr}, 64'd0);

    // srai x5, x6, 33: 6-bit shamt on RV64, illegal on RV32
    drive(1'b1, 32'h4213_5293, 64'h0000_0000_8000_0020);
    step();
    chk("srai_alu", {60'd0, out_alu_ctr}, 64'd7);
    chk("srai_imm", out_imm, 64'd33);
    chk("srai_illegal", {63'd0, out_illegal}, 64'd0);
    chk("srai32_illegal", {63'd0, b_out_illegal}, 64'd1);

    // jal x1, 8
    drive(1'b1, 32'h0080_00EF, 64'h0000_0000_8000_0024);
    step();
    chk("jal_jump", {63'd0, out_jump}, 64'd1);
    chk("jal_alu", {60'd0, out_alu_ctr}, 64'd11);
    chk("jal_asrc", {63'd0, out_asrc}, 64'd1);
    chk("jal_imm", out_imm, 64'd8);
    chk("jal_reg_wr", {63'd0, out_reg_wr}, 64'd1);

    // unknown opcode still passes with valid
    drive(1'b1, 32'h0000_007F, 64'h0000_0000_8000_0028);
    step();
    chk("ill_valid", {63'd0, out_valid}, 64'd1);
    chk("ill_flag", {63'd0, out_illegal}, 64'd1);
    chk("ill_reg_wr", {63'd0, out_reg_wr}, 64'd0);

    // ebreak, then an addi that must never be accepted
    drive(1'b1, 32'h0010_0073, 64'h0000_0000_8000_002C);
    step();
    chk("ebreak_halt", {63'd0, halt}, 64'd1);
    chk("ebreak_valid", {63'd0, out_valid}, 64'd1);
    chk("ebreak_reg_wr", {63'd0, out_reg_wr}, 64'd0);
    chk("ebreak_illegal", {63'd0, out_illegal}, 64'd0);
    chk("ebreak_pc", out_pc, 64'h0000_0000_8000_002C);
    drive(1'b1, 32'hFFF0_0093, 64'h0000_0000_8000_0030);
    #1;
    chk("halt_in_ready", {63'd0, in_ready}, 64'd0);
    step();
    chk("halt_no_accept", {63'd0, out_valid}, 64'd0);
    chk("halt_sticky", {63'd0, halt}, 64'd1);
    step();
    chk("halt_no_accept2", {63'd0, out_valid}, 64'd0);
    chk("halt_in_ready2", {63'd0, in_ready}, 64'd0);

    // asynchronous reset clears halt
    rst_n = 1'b0;
    #1;
    chk("rerst_halt", {63'd0, halt}, 64'd0);
    chk("rerst_valid", {63'd0, out_valid}, 64'd0);
    chk("rerst_in_ready", {63'd0, in_ready}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
